id_ex_stage_register: RTL and testbench

- Pipeline register between the decode stage and the execute stage of the 5-stage RISC-V pipeline.
- Latches the decode control word produced by the control unit, plus the register-file operands, immediate, PC and register indices.
- Contains the load-use hazard detector. It freezes PC and IF/ID through Stall_o and inserts a bubble into EX.
- Also handles branch flush and a global pipeline hold, and keeps a saturating count of inserted load-use bubbles for performance debug.

---
 rtl/id_ex_stage_register_if.sv | 70 +++++++
 rtl/id_ex_stage_register.sv | 122 ++++++++++++
 tb/tb_id_ex_stage_register.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_register_if.sv
// id_ex_if: signal bundle between the decode stage and the ID/EX pipeline
// register.
//   *_i : decoded instruction, operands and pipeline controls (Flush/Hold)
//         coming from the ID stage and the pipeline control logic.
//   *_o : registered EX-stage copies, plus Stall_o (combinational load-use
//         stall toward PC and IF/ID) and Bubble_Count_o (saturating count
//         of load-use bubbles).
// The master modport drives the ID side. The slave modport is the register.
interface id_ex_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  Valid_i;
  logic                  Branch_i;
  logic                  Mem_Read_i;
  logic                  Mem_to_Reg_i;
  logic                  Mem_Write_i;
  logic                  ALU_Src_i;
  logic                  Reg_Write_i;
  logic [2:0]            ALU_Op_i;
  logic [DATA_WIDTH-1:0] PC_i;
  logic [DATA_WIDTH-1:0] Read_Data_1_i;
  logic [DATA_WIDTH-1:0] Read_Data_2_i;
  logic [DATA_WIDTH-1:0] Immediate_i;
  logic [4:0]            Rs1_i;
  logic [4:0]            Rs2_i;
  logic [4:0]            Rd_i;
  logic [2:0]            Funct3_i;
  logic                  Funct7_b5_i;
  logic                  Flush_i;
  logic                  Hold_i;

  logic                  Valid_o;
  logic                  Branch_o;
  logic                  Mem_Read_o;
  logic                  Mem_to_Reg_o;
  logic                  Mem_Write_o;
  logic                  ALU_Src_o;
  logic                  Reg_Write_o;
  logic [2:0]            ALU_Op_o;
  logic [DATA_WIDTH-1:0] PC_o;
  logic [DATA_WIDTH-1:0] Read_Data_1_o;
  logic [DATA_WIDTH-1:0] Read_Data_2_o;
  logic [DATA_WIDTH-1:0] Immediate_o;
  logic [4:0]            Rs1_o;
  logic [4:0]            Rs2_o;
  logic [4:0]            Rd_o;
  logic [2:0]            Funct3_o;
  logic                  Funct7_b5_o;
  logic                  Stall_o;
  logic [CNT_WIDTH-1:0]  Bubble_Count_o;

  modport master (
    output Valid_i, Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i,
           Reg_Write_i, ALU_Op_i, PC_i, Read_Data_1_i, Read_Data_2_i, Immediate_i,
           Rs1_i, Rs2_i, Rd_i, Funct3_i, Funct7_b5_i, Flush_i, Hold_i,
    input  Valid_o, Branch_o, Mem_Read_o, Mem_to_Reg_o, Mem_Write_o, ALU_Src_o,
           Reg_Write_o, ALU_Op_o, PC_o, Read_Data_1_o, Read_Data_2_o, Immediate_o,
           Rs1_o, Rs2_o, Rd_o, Funct3_o, Funct7_b5_o, Stall_o, Bubble_Count_o
  );

  modport slave (
    input  Valid_i, Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i,
           Reg_Write_i, ALU_Op_i, PC_i, Read_Data_1_i, Read_Data_2_i, Immediate_i,
           Rs1_i, Rs2_i, Rd_i, Funct3_i, Funct7_b5_i, Flush_i, Hold_i,
    output Valid_o, Branch_o, Mem_Read_o, Mem_to_Reg_o, Mem_Write_o, ALU_Src_o,
           Reg_Write_o, ALU_Op_o, PC_o, Read_Data_1_o, Read_Data_2_o, Immediate_o,
           Rs1_o, Rs2_o, Rd_o, Funct3_o, Funct7_b5_o, Stall_o, Bubble_Count_o
  );
endinterface

// File: rtl/id_ex_stage_register.sv
// id_ex_stage_register: ID/EX pipeline register of the 5-stage RISC-V core.
// It also contains the load-use hazard detector.
//   clk   : pipeline clock, rising edge
//   reset : synchronous, active-high; clears every register
//   bus   : id_ex_if.slave; decoded ID instruction in, EX copies out,
//           Stall_o (freeze PC and IF/ID) and Bubble_Count_o (saturating)
// Edge priority: reset > Flush_i > Hold_i > load-use bubble > normal load.
module id_ex_stage_register #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic   clk,
  input  logic   reset,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic                  branch;
    logic                  mem_read;
    logic                  mem_to_reg;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_write;
    logic [2:0]            alu_op;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic                  funct7_b5;
  } stage_t;

  stage_t               stage_d, stage_q;
  logic [CNT_WIDTH-1:0] bubble_cnt_d, bubble_cnt_q;
  logic                 hazard;

  // EX holds a load whose destination the ID instruction reads. Both
  // sources are compared even when rs2 is unused, so some stalls are false.
  // x0 never causes a stall.
  always_comb begin
    hazard = stage_q.valid && stage_q.mem_read && (stage_q.rd != 5'd0) &&
             bus.Valid_i &&
             ((stage_q.rd == bus.Rs1_i) || (stage_q.rd == bus.Rs2_i));
  end

  // Flush kills the ID instruction, so the stall is not needed. Hold is not
  // applied here; PC and IF/ID stay frozen either way.
  assign bus.Stall_o = hazard & ~bus.Flush_i;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;

    if (bus.Flush_i) begin
      stage_d = '0;
    end else if (!bus.Hold_i) begin
      if (hazard) begin
        stage_d = '0;
        if (bubble_cnt_q != '1) begin
          bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
        end
      end else begin
        // The data fields load as they are. Control is gated by Valid_i, so
        // an empty slot cannot write state downstream.
        stage_d.valid      = bus.Valid_i;
        stage_d.branch     = bus.Valid_i & bus.Branch_i;
        stage_d.mem_read   = bus.Valid_i & bus.Mem_Read_i;
        stage_d.mem_to_reg = bus.Valid_i & bus.Mem_to_Reg_i;
        stage_d.mem_write  = bus.Valid_i & bus.Mem_Write_i;
        stage_d.alu_src    = bus.Valid_i & bus.ALU_Src_i;
        stage_d.reg_write  = bus.Valid_i & bus.Reg_Write_i;
        stage_d.alu_op     = bus.Valid_i ? bus.ALU_Op_i : 3'b000;
        stage_d.pc         = bus.PC_i;
        stage_d.rd1        = bus.Read_Data_1_i;
        stage_d.rd2        = bus.Read_Data_2_i;
        stage_d.imm        = bus.Immediate_i;
        stage_d.rs1        = bus.Rs1_i;
        stage_d.rs2        = bus.Rs2_i;
        stage_d.rd         = bus.Rd_i;
        stage_d.funct3     = bus.Funct3_i;
        stage_d.funct7_b5  = bus.Funct7_b5_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments. All flops then sample
    // the values from before the edge, whatever order the blocks run in.
    if (reset) begin
      stage_q      <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.Valid_o        = stage_q.valid;
  assign bus.Branch_o       = stage_q.branch;
  assign bus.Mem_Read_o     = stage_q.mem_read;
  assign bus.Mem_to_Reg_o   = stage_q.mem_to_reg;
  assign bus.Mem_Write_o    = stage_q.mem_write;
  assign bus.ALU_Src_o      = stage_q.alu_src;
  assign bus.Reg_Write_o    = stage_q.reg_write;
  assign bus.ALU_Op_o       = stage_q.alu_op;
  assign bus.PC_o           = stage_q.pc;
  assign bus.Read_Data_1_o  = stage_q.rd1;
  assign bus.Read_Data_2_o  = stage_q.rd2;
  assign bus.Immediate_o    = stage_q.imm;
  assign bus.Rs1_o          = stage_q.rs1;
  assign bus.Rs2_o          = stage_q.rs2;
  assign bus.Rd_o           = stage_q.rd;
  assign bus.Funct3_o       = stage_q.funct3;
  assign bus.Funct7_b5_o    = stage_q.funct7_b5;
  assign bus.Bubble_Count_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Self-checking bench for id_ex_stage_register. A 16-bit counter instance
// and a 2-bit counter instance (for saturation) share identical stimulus.
module tb_id_ex_stage_register;

  typedef struct packed {
    logic        valid;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic [2:0]  alu_op;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
  } word_t;

  typedef struct packed {
    word_t w;
    logic  flush;
    logic  hold;
  } in_t;

  typedef struct {
    in_t         in;
    bit          stall;
    bit          v;
    bit          mr;
    bit          rw;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] pc;
    int unsigned cnt;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  id_ex_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();
  id_ex_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  bus_s ();

  id_ex_stage_register #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  id_ex_stage_register #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus_s)
  );

  // The saturation instance sees exactly the same ID-side inputs.
  assign bus_s.Valid_i       = bus.Valid_i;
  assign bus_s.Branch_i      = bus.Branch_i;
  assign bus_s.Mem_Read_i    = bus.Mem_Read_i;
  assign bus_s.Mem_to_Reg_i  = bus.Mem_to_Reg_i;
  assign bus_s.Mem_Write_i   = bus.Mem_Write_i;
  assign bus_s.ALU_Src_i     = bus.ALU_Src_i;
  assign bus_s.Reg_Write_i   = bus.Reg_Write_i;
  assign bus_s.ALU_Op_i      = bus.ALU_Op_i;
  assign bus_s.PC_i          = bus.PC_i;
  assign bus_s.Read_Data_1_i = bus.Read_Data_1_i;
  assign bus_s.Read_Data_2_i = bus.Read_Data_2_i;
  assign bus_s.Immediate_i   = bus.Immediate_i;
  assign bus_s.Rs1_i         = bus.Rs1_i;
  assign bus_s.Rs2_i         = bus.Rs2_i;
  assign bus_s.Rd_i          = bus.Rd_i;
  assign bus_s.Funct3_i      = bus.Funct3_i;
  assign bus_s.Funct7_b5_i   = bus.Funct7_b5_i;
  assign bus_s.Flush_i       = bus.Flush_i;
  assign bus_s.Hold_i        = bus.Hold_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Reference model: the instruction sitting in EX, plus an unbounded count
  // of bubbles. The DUT counters must show that count clamped to their width.
  word_t       ex_m;
  int unsigned cnt_m;
  bit          known = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic int unsigned clamp(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic word_t dut_word();
    word_t w;
    w.valid      = bus.Valid_o;
    w.branch     = bus.Branch_o;
    w.mem_read   = bus.Mem_Read_o;
    w.mem_to_reg = bus.Mem_to_Reg_o;
    w.mem_write  = bus.Mem_Write_o;
    w.alu_src    = bus.ALU_Src_o;
    w.reg_write  = bus.Reg_Write_o;
    w.alu_op     = bus.ALU_Op_o;
    w.pc         = bus.PC_o;
    w.rd1        = bus.Read_Data_1_o;
    w.rd2        = bus.Read_Data_2_o;
    w.imm        = bus.Immediate_o;
    w.rs1        = bus.Rs1_o;
    w.rs2        = bus.Rs2_o;
    w.rd         = bus.Rd_o;
    w.f3         = bus.Funct3_o;
    w.f7         = bus.Funct7_b5_o;
    return w;
  endfunction

  task automatic drive(input in_t s);
    bus.Valid_i       = s.w.valid;
    bus.Branch_i      = s.w.branch;
    bus.Mem_Read_i    = s.w.mem_read;
    bus.Mem_to_Reg_i  = s.w.mem_to_reg;
    bus.Mem_Write_i   = s.w.mem_write;
    bus.ALU_Src_i     = s.w.alu_src;
    bus.Reg_Write_i   = s.w.reg_write;
    bus.ALU_Op_i      = s.w.alu_op;
    bus.PC_i          = s.w.pc;
    bus.Read_Data_1_i = s.w.rd1;
    bus.Read_Data_2_i = s.w.rd2;
    bus.Immediate_i   = s.w.imm;
    bus.Rs1_i         = s.w.rs1;
    bus.Rs2_i         = s.w.rs2;
    bus.Rd_i          = s.w.rd;
    bus.Funct3_i      = s.w.f3;
    bus.Funct7_b5_i   = s.w.f7;
    bus.Flush_i       = s.flush;
    bus.Hold_i        = s.hold;
  endtask

  // The ID instruction needs a result that the load in EX has not produced.
  function automatic bit load_use(input in_t s);
    return known && ex_m.valid && ex_m.mem_read && ex_m.rd != 5'd0 && s.w.valid &&
           (ex_m.rd == s.w.rs1 || ex_m.rd == s.w.rs2);
  endfunction

  // One clock cycle. Inputs are applied at the falling edge and the stall is
  // sampled 1 ns later. The registers are sampled 1 ns after the rising edge.
  task automatic step(input in_t s, input bit rst, output bit stall_seen);
    bit lu;
    @(negedge clk);
    drive(s);
    reset = rst;
    #1;
    stall_seen = bus.Stall_o;
    lu = load_use(s);
    if (known) begin
      check("stall", 160'(bus.Stall_o), 160'(lu && !s.flush));
      check("stall_sat", 160'(bus_s.Stall_o), 160'(lu && !s.flush));
    end
    @(posedge clk);
    #1;
    if (rst) begin
      ex_m  = '0;
      cnt_m = 0;
      known = 1'b1;
    end else if (s.flush) begin
      ex_m = '0;
    end else if (!s.hold) begin
      if (lu) begin
        ex_m = '0;
        cnt_m++;
      end else begin
        ex_m = s.w;
        if (!s.w.valid) begin
          {ex_m.branch, ex_m.mem_read, ex_m.mem_to_reg, ex_m.mem_write,
           ex_m.alu_src, ex_m.reg_write, ex_m.alu_op} = '0;
        end
      end
    end
    if (known) begin
      check("regs", 160'(dut_word()), 160'(ex_m));
      check("bubble_cnt", 160'(bus.Bubble_Count_o), 160'(clamp(cnt_m, 65535)));
      check("bubble_cnt_sat", 160'(bus_s.Bubble_Count_o), 160'(clamp(cnt_m, 3)));
    end
  endtask

  function automatic in_t mk(input bit v, input bit mr, input bit rw, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] pc, input bit fl, input bit hd);
    in_t s;
    s.w.valid      = v;
    s.w.branch     = 1'b0;
    s.w.mem_read   = mr;
    s.w.mem_to_reg = mr;
    s.w.mem_write  = 1'b0;
    s.w.alu_src    = mr;
    s.w.reg_write  = rw;
    s.w.alu_op     = mr ? 3'b000 : 3'b010;
    s.w.pc         = pc;
    s.w.rd1        = pc ^ 32'hA5A5_0000;
    s.w.rd2        = ~pc;
    s.w.imm        = pc + 32'd4;
    s.w.rs1        = rs1;
    s.w.rs2        = rs2;
    s.w.rd         = rd;
    s.w.f3         = rd[2:0];
    s.w.f7         = rs1[0];
    s.flush        = fl;
    s.hold         = hd;
    return s;
  endfunction

  function automatic in_t rnd_in();
    in_t s;
    s.w.valid      = ($urandom_range(0, 3) != 0);
    s.w.branch     = 1'($urandom);
    s.w.mem_read   = 1'($urandom);
    s.w.mem_to_reg = 1'($urandom);
    s.w.mem_write  = 1'($urandom);
    s.w.alu_src    = 1'($urandom);
    s.w.reg_write  = 1'($urandom);
    s.w.alu_op     = 3'($urandom);
    s.w.pc         = $urandom;
    s.w.rd1        = $urandom;
    s.w.rd2        = $urandom;
    s.w.imm        = $urandom;
    s.w.rs1        = 5'($urandom_range(0, 3));
    s.w.rs2        = 5'($urandom_range(0, 3));
    s.w.rd         = 5'($urandom_range(0, 3));
    s.w.f3         = 3'($urandom);
    s.w.f7         = 1'($urandom);
    s.flush        = ($urandom_range(0, 7) == 0);
    s.hold         = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  vec_t tbl[20];
  bit   st;

  initial begin
    // Rows run in order after reset. The stall is observed before the edge
    // and the other fields after it.
    //             v  mr rw rs1 rs2 rd  pc         fl hd     stall v mr rw rd rs1 pc   cnt
    tbl[0]  = '{mk(1, 0, 1, 1,  2,  5,  32'h100, 0, 0), 0, 1, 0, 1, 5,  1,  32'h100, 0};
    tbl[1]  = '{mk(1, 1, 1, 2,  0,  7,  32'h104, 0, 0), 0, 1, 1, 1, 7,  2,  32'h104, 0};
    tbl[2]  = '{mk(1, 0, 1, 7,  3,  8,  32'h108, 0, 0), 1, 0, 0, 0, 0,  0,  32'h0,   1};
    tbl[3]  = '{mk(1, 0, 1, 7,  3,  8,  32'h108, 0, 0), 0, 1, 0, 1, 8,  7,  32'h108, 1};
    tbl[4]  = '{mk(1, 1, 1, 1,  0,  0,  32'h10c, 0, 0), 0, 1, 1, 1, 0,  1,  32'h10c, 1};
    tbl[5]  = '{mk(1, 0, 1, 0,  0,  9,  32'h110, 0, 0), 0, 1, 0, 1, 9,  0,  32'h110, 1};
    tbl[6]  = '{mk(1, 1, 1, 1,  2,  3,  32'h114, 0, 0), 0, 1, 1, 1, 3,  1,  32'h114, 1};
    tbl[7]  = '{mk(1, 0, 1, 4,  5,  10, 32'h118, 0, 0), 0, 1, 0, 1, 10, 4,  32'h118, 1};
    tbl[8]  = '{mk(1, 1, 1, 1,  1,  6,  32'h11c, 0, 0), 0, 1, 1, 1, 6,  1,  32'h11c, 1};
    tbl[9]  = '{mk(1, 1, 1, 0,  6,  11, 32'h120, 0, 0), 1, 0, 0, 0, 0,  0,  32'h0,   2};
    tbl[10] = '{mk(1, 1, 1, 0,  6,  11, 32'h120, 0, 0), 0, 1, 1, 1, 11, 0,  32'h120, 2};
    tbl[11] = '{mk(1, 0, 1, 11, 2,  12, 32'h124, 1, 1), 0, 0, 0, 0, 0,  0,  32'h0,   2};
    tbl[12] = '{mk(1, 0, 1, 1,  2,  13, 32'h128, 0, 0), 0, 1, 0, 1, 13, 1,  32'h128, 2};
    tbl[13] = '{mk(1, 1, 1, 13, 2,  20, 32'h200, 0, 1), 0, 1, 0, 1, 13, 1,  32'h128, 2};
    tbl[14] = '{mk(0, 1, 0, 7,  9,  21, 32'h204, 0, 1), 0, 1, 0, 1, 13, 1,  32'h128, 2};
    tbl[15] = '{mk(1, 0, 1, 3,  13, 22, 32'h208, 0, 1), 0, 1, 0, 1, 13, 1,  32'h128, 2};
    tbl[16] = '{mk(1, 1, 1, 1,  2,  14, 32'h12c, 0, 0), 0, 1, 1, 1, 14, 1,  32'h12c, 2};
    tbl[17] = '{mk(1, 0, 1, 14, 2,  15, 32'h130, 0, 1), 1, 1, 1, 1, 14, 1,  32'h12c, 2};
    tbl[18] = '{mk(1, 0, 1, 14, 2,  15, 32'h130, 0, 0), 1, 0, 0, 0, 0,  0,  32'h0,   3};
    tbl[19] = '{mk(0, 1, 1, 3,  4,  16, 32'h134, 0, 0), 0, 0, 0, 0, 16, 3,  32'h134, 3};

    reset = 1'b1;
    drive(rnd_in());

    // Reset for two cycles with random inputs.
    step(rnd_in(), 1'b1, st);
    check("reset_regs", 160'(dut_word()), 160'(0));
    check("reset_stall", 160'(bus.Stall_o), 160'(0));
    check("reset_cnt", 160'(bus.Bubble_Count_o), 160'(0));
    step(rnd_in(), 1'b1, st);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].in, 1'b0, st);
      check($sformatf("t%0d_stall", i), 160'(st), 160'(tbl[i].stall));
      check($sformatf("t%0d_valid", i), 160'(bus.Valid_o), 160'(tbl[i].v));
      check($sformatf("t%0d_mem_read", i), 160'(bus.Mem_Read_o), 160'(tbl[i].mr));
      check($sformatf("t%0d_reg_write", i), 160'(bus.Reg_Write_o), 160'(tbl[i].rw));
      check($sformatf("t%0d_rd", i), 160'(bus.Rd_o), 160'(tbl[i].rd));
      check($sformatf("t%0d_rs1", i), 160'(bus.Rs1_o), 160'(tbl[i].rs1));
      check($sformatf("t%0d_pc", i), 160'(bus.PC_o), 160'(tbl[i].pc));
      check($sformatf("t%0d_cnt", i), 160'(bus.Bubble_Count_o), 160'(tbl[i].cnt));
    end

    // Saturation: three more load-use bubbles, six in total.
    for (int k = 0; k < 3; k++) begin
      step(mk(1, 1, 1, 1, 2, 9, 32'h300, 0, 0), 1'b0, st);
      step(mk(1, 0, 1, 9, 2, 17, 32'h304, 0, 0), 1'b0, st);
      check($sformatf("sat%0d_stall", k), 160'(st), 160'(1));
      step(mk(1, 0, 1, 9, 2, 17, 32'h304, 0, 0), 1'b0, st);
    end
    check("sat_cnt_final", 160'(bus_s.Bubble_Count_o), 160'(2'd3));
    check("main_cnt_final", 160'(bus.Bubble_Count_o), 160'(16'd6));

    // Reset arriving while a stall is showing.
    step(mk(1, 1, 1, 1, 2, 9, 32'h400, 0, 0), 1'b0, st);
    step(mk(1, 0, 1, 9, 2, 18, 32'h404, 0, 0), 1'b1, st);
    check("rst_mid_pre_stall", 160'(st), 160'(1));
    check("rst_mid_post_stall", 160'(bus.Stall_o), 160'(0));
    check("rst_mid_regs", 160'(dut_word()), 160'(0));
    check("rst_mid_cnt", 160'(bus.Bubble_Count_o), 160'(0));

    // Random traffic. The small register-index range makes hazards common.
    for (int n = 0; n < 400; n++) begin
      step(rnd_in(), ($urandom_range(0, 63) == 0), st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
